rx_control_unit: RTL and testbench

Receive control unit for the UART receiver. Sequences the bit-timer, the stop-bit checker and the receive-buffer load for each incoming frame: it detects the frame start, runs the timer for the whole packet, qualifies the stop bit and either commits the byte or drops it on a framing error. It sits between the start-bit detector and the timer, stop-bit checker and receive buffer, and is the only block that drives their control strobes.

---
 rtl/rx_control_unit.sv | 150 +++++++++++++++
 tb/tb_rx_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_control_unit.sv
// rx_control_unit: UART receive sequencer driving timer, stop-bit checker
// and receive-buffer strobes from a six-state Moore FSM.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   start_bit_detected  start pulse (sampled in IDLE)
//   packet_done         timer end-of-packet (sampled in RECEIVE)
//   framing_error       stop-bit checker result (sampled in CHECK)
//   sbc_clear           stop-bit checker clear (CLEAR)
//   sbc_enable          stop-bit checker strobe (STOP)
//   enable_timer        bit-timer run (RECEIVE)
//   load_buffer         commit byte (LOAD)
//   rx_timeout          watchdog abort pulse, registered
//
// Optional: define RX_TIMEOUT_EN to build the RECEIVE watchdog
// (limit TIMEOUT_CYCLES, legal 2..1023). Without it rx_timeout is 0.
module rx_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 120
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic packet_done,
  input  logic framing_error,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic enable_timer,
  output logic load_buffer,
  output logic rx_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RECEIVE = 3'd2,
    STOP    = 3'd3,
    CHECK   = 3'd4,
    LOAD    = 3'd5
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   wd_abort;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt_q;
  logic [CW-1:0] wd_cnt_d;
  logic          rx_timeout_q;
  logic          rx_timeout_d;

  // CLEAR always precedes RECEIVE, so zeroing there
  // gives a count of 0 in the first RECEIVE cycle.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == CLEAR) begin
      wd_cnt_d = '0;
    end else if (state_q == RECEIVE) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // packet_done on the limit cycle takes priority.
  assign wd_abort = (state_q == RECEIVE) &&
                    (wd_cnt_q == LIMIT) &&
                    !packet_done;

  assign rx_timeout_d = wd_abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_q     <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q     <= wd_cnt_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign rx_timeout = rx_timeout_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign wd_abort   = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_bit_detected) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = RECEIVE;
      end
      RECEIVE: begin
        if (packet_done) begin
          state_d = STOP;
        end else if (wd_abort) begin
          state_d = IDLE;
        end
      end
      STOP: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (framing_error) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sbc_clear    = 1'b0;
    sbc_enable   = 1'b0;
    enable_timer = 1'b0;
    load_buffer  = 1'b0;
    unique case (state_q)
      CLEAR:   sbc_clear    = 1'b1;
      RECEIVE: enable_timer = 1'b1;
      STOP:    sbc_enable   = 1'b1;
      LOAD:    load_buffer  = 1'b1;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_rx_control_unit.sv
// tb_rx_control_unit: scoreboard bench for rx_control_unit.
// Output vector is {rx_timeout, load_buffer, sbc_enable, enable_timer, sbc_clear}.
module tb_rx_control_unit;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } ev_t;

  localparam logic [4:0] V_0   = 5'b00000;
  localparam logic [4:0] V_CLR = 5'b00001;
  localparam logic [4:0] V_TMR = 5'b00010;
  localparam logic [4:0] V_SBE = 5'b00100;
  localparam logic [4:0] V_LD  = 5'b01000;
  localparam logic [4:0] V_TO  = 5'b10000;

`ifdef RX_TIMEOUT_EN
  localparam int LONG = 21;
`else
  localparam int LONG = 92;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_bit_detected = 1'b0;
  logic packet_done = 1'b0;
  logic framing_error = 1'b0;
  logic sbc_clear;
  logic sbc_enable;
  logic enable_timer;
  logic load_buffer;
  logic rx_timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  ev_t exp_q[$];
  logic [4:0] prev = 5'b0;

  rx_control_unit #(.TIMEOUT_CYCLES(20)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_bit_detected (start_bit_detected),
    .packet_done        (packet_done),
    .framing_error      (framing_error),
    .sbc_clear          (sbc_clear),
    .sbc_enable         (sbc_enable),
    .enable_timer       (enable_timer),
    .load_buffer        (load_buffer),
    .rx_timeout         (rx_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [4:0] outv();
    return {rx_timeout, load_buffer, sbc_enable,
            enable_timer, sbc_clear};
  endfunction

  // Monitor: every change of the output vector must match the next
  // expected event, both in value and in cycle.
  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t e;
    cur = outv();
    tests++;
    if (!$onehot0(cur[3:0])) begin
      fails++;
      $display("FAIL onehot cyc=%0d got=%b required=at most one strobe",
               cyc, cur);
    end
    if (cur !== prev) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=%b",
                 cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== cur) begin
          fails++;
          $display("FAIL event cyc=%0d got=%b required cyc=%0d vec=%b",
                   cyc, cur, e.cyc, e.v);
        end
      end
      prev = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (outv() !== V_0) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b required=%b",
               name, cyc, outv(), V_0);
    end
  endtask

  // Start driven at cyc t0 is sampled at edge t0+1; packet_done
  // driven at cyc m (=t0+len) is sampled at edge m+1.
  task automatic run_frame(input int len, input bit fe, input bit spur);
    int t0;
    int m;
    t0 = cyc;
    m = t0 + len;
    start_bit_detected = 1'b1;
    framing_error = fe;
    push(t0 + 1, V_CLR);
    push(t0 + 2, V_TMR);
    step();
    start_bit_detected = 1'b0;
    while (cyc < m) begin
      start_bit_detected = spur && (cyc == t0 + 4);
      step();
    end
    start_bit_detected = 1'b0;
    packet_done = 1'b1;
    push(m + 1, V_SBE);
    push(m + 2, V_0);
    if (!fe) begin
      push(m + 3, V_LD);
      push(m + 4, V_0);
    end
    step();
    packet_done = 1'b0;
    start_bit_detected = spur;
    step();
    start_bit_detected = 1'b0;
    while (cyc < (fe ? m + 3 : m + 4)) step();
    framing_error = 1'b0;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 4; i++) begin
      start_bit_detected = 1'($urandom_range(0, 1));
      packet_done = 1'($urandom_range(0, 1));
      framing_error = 1'($urandom_range(0, 1));
      step();
      check_zero("reset_hold");
    end
    start_bit_detected = 1'b0;
    packet_done = 1'b0;
    framing_error = 1'b0;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_zero("post_reset_idle");
    end

    run_frame(LONG, 1'b0, 1'b0);
    run_frame(LONG, 1'b1, 1'b0);
    run_frame(LONG, 1'b0, 1'b0);
    run_frame(LONG, 1'b0, 1'b1);

    // Mid-frame reset during RECEIVE.
    t0 = cyc;
    start_bit_detected = 1'b1;
    push(t0 + 1, V_CLR);
    push(t0 + 2, V_TMR);
    step();
    start_bit_detected = 1'b0;
    while (cyc < t0 + 10) step();
    n_rst = 1'b0;
    push(t0 + 10, V_0);
    #1;
    tests++;
    if (enable_timer !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got=%b required=0", enable_timer);
    end
    step();
    step();
    n_rst = 1'b1;
    repeat (3) step();
    run_frame(LONG, 1'b0, 1'b0);

`ifdef RX_TIMEOUT_EN
    t0 = cyc;
    start_bit_detected = 1'b1;
    push(t0 + 1, V_CLR);
    push(t0 + 2, V_TMR);
    push(t0 + 22, V_TO);
    push(t0 + 23, V_0);
    step();
    start_bit_detected = 1'b0;
    while (cyc < t0 + 26) step();
`endif

    repeat (4) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
